acc_datapath: RTL and testbench
===============================

Name: acc_datapath

Overview:
- Execution datapath of the accumulator CPU, directly downstream of the instruction decoder.
- Consumes the decoder control bits (SelA, SelB, WrAcc, Op, WrRam, RdRam) and the 11-bit instruction operand.
- Holds the accumulator, the data RAM, the add/sub ALU and the status flags.
- Executes one instruction per clock.

Parameters:
- B, 16, data width in bits (accumulator, RAM word, ALU).
- A, 11, operand field width in bits (immediate value / RAM address).
- D, 10, data RAM address width; depth is 2^D words. Requires D <= A.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Operand  in  A  operand field of the current instruction.
- SelA  in  2  accumulator source: 00 RAM data, 01 sign-extended immediate, 10 ALU result, 11 hold.
- SelB  in  1  ALU second operand: 0 RAM data, 1 sign-extended immediate.
- WrAcc  in  1  accumulator write enable.
- Op  in  1  ALU operation: 0 add, 1 subtract.
- WrRam  in  1  data RAM write enable.
- RdRam  in  1  data RAM read enable.
- Acc  out  B  current accumulator value (registered).
- RamRdData  out  B  gated RAM read data (combinational).
- Zero  out  1  accumulator-equals-zero flag (registered).
- Neg  out  1  accumulator MSB flag (registered).
- Ovf  out  1  sticky signed-overflow flag (registered).

Behaviour:
- One clock domain. Reset is synchronous and active-high, and takes priority over every other input.
- Reset values: Acc=0, Zero=0, Neg=0, Ovf=0.
  - No RAM write happens in a reset cycle, even if WrRam=1.
  - Reset does not clear RAM contents. The simulation model initialises RAM to all zeros.
- ImmExt = Operand sign-extended from A bits to B bits (bit A-1 replicated).
- Addr = Operand[D-1:0]. Operand bits above D are ignored, so addresses alias modulo 2^D.
- RAM read:
  - Asynchronous (distributed-style).
  - RamRdData = mem[Addr] when RdRam=1, else 0.
  - A read always returns the contents stored before the current edge.
- ALU:
  - BOp = SelB ? ImmExt : RamRdData.
  - AluRes = Op ? Acc - BOp : Acc + BOp, truncated to B bits (two's-complement wrap, no saturation).
- Accumulator update at the edge when WrAcc=1:
  - SelA=00: Acc <= RamRdData.
  - SelA=01: Acc <= ImmExt.
  - SelA=10: Acc <= AluRes.
  - SelA=11: Acc holds.
  - WrAcc=0: Acc holds regardless of SelA.
- RAM write at the edge when WrRam=1: mem[Addr] <= Acc, using the value of Acc before this edge.
- Simultaneous events:
  - WrRam=1 and WrAcc=1 in the same cycle: RAM stores the old Acc; Acc takes its new value.
  - WrRam=1 and RdRam=1 at the same Addr: RamRdData and any Acc load see the old word; the new word is visible next cycle.
- Flags:
  - Zero and Neg are updated only on cycles where Acc is actually written, i.e. WrAcc=1 and SelA!=11.
  - Zero = (new Acc == 0). Neg = new Acc[B-1]. Otherwise both hold.
- Ovf:
  - Set when WrAcc=1, SelA=10 and the add/sub signed-overflows.
  - Add overflows when Acc[B-1]==BOp[B-1] and AluRes[B-1]!=Acc[B-1].
  - Subtract overflows when Acc[B-1]!=BOp[B-1] and AluRes[B-1]!=Acc[B-1].
  - Ovf is cleared only by reset.
- Latency: the result of an instruction is visible on Acc and the flags one cycle after the edge that executes it. A following instruction uses the updated Acc with no stall or forwarding required.
- Halt/NOP (all controls 0): no state change.
- Undefined control combinations (SelA=11 with WrAcc=1) behave as hold; they are not errors.

Test Plan:
- Reset, then load immediate (SelA=01, WrAcc=1, Operand=11'h005) -> Acc=16'h0005, Zero=0, Neg=0 one cycle later.
- Load immediate Operand=11'h7FF -> Acc=16'hFFFF, Neg=1. Then add immediate 11'h001 (SelA=10, SelB=1, Op=0) -> Acc=16'h0000, Zero=1, Ovf=0.
- Acc=16'h1234; store to addr 3 (WrRam=1); load immediate 0; load variable addr 3 (SelA=00, RdRam=1) -> Acc=16'h1234. Repeat with Operand=11'h403 (aliased) -> same word returned.
- Acc=16'h7FFF, add immediate 1 -> Acc=16'h8000, Ovf=1, Neg=1. Then subtract immediate 0 -> Ovf remains 1. Assert reset -> Ovf=0, Acc=0.
- Same-cycle store and load-variable at addr 5, old mem[5]=16'h00AA, Acc=16'h0055 -> Acc=16'h00AA, and mem[5]=16'h0055 is readable next cycle.
- Reset asserted together with WrRam=1 and WrAcc=1 -> Acc=0, flags 0, target RAM word unchanged. RdRam=0 -> RamRdData=0 for any Addr.

Source files
------------

// File: rtl/acc_datapath_if.sv
// ---------------------------------------------------------------------------
// acc_datapath_if
//   Bundles the decoder-to-datapath control/operand signals and the datapath
//   status outputs of the accumulator CPU.
//   master : instruction decoder side (drives controls, observes status)
//   slave  : acc_datapath side
//   Signals:
//     Operand   [A-1:0] immediate value / RAM address field
//     SelA      [1:0]   accumulator source (00 RAM, 01 imm, 10 ALU, 11 hold)
//     SelB              ALU operand B (0 RAM, 1 imm)
//     WrAcc, Op, WrRam, RdRam  write/op/read controls
//     Acc       [B-1:0] accumulator (registered)
//     RamRdData [B-1:0] gated RAM read data (combinational)
//     Zero, Neg, Ovf    status flags (registered)
// ---------------------------------------------------------------------------
interface acc_datapath_if #(
    parameter int A = 11,
    parameter int B = 16
);
    logic [A-1:0] Operand;
    logic [1:0]   SelA;
    logic         SelB;
    logic         WrAcc;
    logic         Op;
    logic         WrRam;
    logic         RdRam;
    logic [B-1:0] Acc;
    logic [B-1:0] RamRdData;
    logic         Zero;
    logic         Neg;
    logic         Ovf;

    modport master (
        output Operand, SelA, SelB, WrAcc, Op, WrRam, RdRam,
        input  Acc, RamRdData, Zero, Neg, Ovf
    );

    modport slave (
        input  Operand, SelA, SelB, WrAcc, Op, WrRam, RdRam,
        output Acc, RamRdData, Zero, Neg, Ovf
    );
endinterface

// File: rtl/acc_datapath.sv
// ---------------------------------------------------------------------------
// acc_datapath
//   Execution datapath of the accumulator CPU: accumulator, 2^D-word data
//   RAM with asynchronous read, add/sub ALU and Zero/Neg/sticky-Ovf flags.
//   One instruction executes per clock.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; blocks RAM writes, clears Acc/flags
//     bus    acc_datapath_if.slave (controls in, Acc/RamRdData/flags out)
//   Assumes D <= A <= B.
// ---------------------------------------------------------------------------
module acc_datapath #(
    parameter int B = 16,
    parameter int A = 11,
    parameter int D = 10
) (
    input  logic          clk,
    input  logic          reset,
    acc_datapath_if.slave bus
);
    localparam int DEPTH = 1 << D;

    // RAM contents are not touched by reset; the declaration initialiser
    // gives simulation (and FPGA bitstreams) a zeroed memory.
    logic [B-1:0] mem_q [DEPTH] = '{default: '0};

    logic [B-1:0] acc_q, acc_d;
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;
    logic         ovf_q, ovf_d;

    logic [B-1:0] imm_ext;
    logic [D-1:0] addr;
    logic [B-1:0] rd_data;
    logic [B-1:0] b_op;
    logic [B-1:0] alu_res;
    logic         alu_ovf;
    logic         acc_wr;

    assign imm_ext = {{(B-A){bus.Operand[A-1]}}, bus.Operand};
    // Upper operand bits are dropped, so addresses alias modulo 2^D.
    assign addr    = bus.Operand[D-1:0];
    // Asynchronous read returns the pre-edge word even when written this cycle.
    assign rd_data = bus.RdRam ? mem_q[addr] : '0;
    assign b_op    = bus.SelB ? imm_ext : rd_data;
    assign alu_res = bus.Op ? (acc_q - b_op) : (acc_q + b_op);

    // Signed overflow: operands (B negated for subtract) share a sign that
    // the result does not.
    always_comb begin
        alu_ovf = 1'b0;
        if (bus.Op)
            alu_ovf = (acc_q[B-1] != b_op[B-1]) && (alu_res[B-1] != acc_q[B-1]);
        else
            alu_ovf = (acc_q[B-1] == b_op[B-1]) && (alu_res[B-1] != acc_q[B-1]);
    end

    // SelA=11 is a hold, so it does not count as an accumulator write.
    assign acc_wr = bus.WrAcc && (bus.SelA != 2'b11);

    always_comb begin
        acc_d  = acc_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (acc_wr) begin
            unique case (bus.SelA)
                2'b00:   acc_d = rd_data;
                2'b01:   acc_d = imm_ext;
                default: acc_d = alu_res;
            endcase
            zero_d = (acc_d == '0);
            neg_d  = acc_d[B-1];
            if (bus.SelA == 2'b10 && alu_ovf)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    // Stores the pre-edge accumulator, so store+load in one cycle is safe.
    always_ff @(posedge clk) begin
        if (!reset && bus.WrRam)
            mem_q[addr] <= acc_q;
    end

    assign bus.Acc       = acc_q;
    assign bus.RamRdData = rd_data;
    assign bus.Zero      = zero_q;
    assign bus.Neg       = neg_q;
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_acc_datapath.sv
module tb_acc_datapath;
    localparam int A = 11;
    localparam int B = 16;
    localparam int D = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    acc_datapath_if #(.A(A), .B(B)) bus();
    acc_datapath #(.B(B), .A(A), .D(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [15:0] m_acc;
    logic        m_z, m_n, m_o;
    logic [15:0] m_mem [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext(input logic [10:0] opnd);
        int v;
        v = opnd[10] ? int'(opnd) - 2048 : int'(opnd);
        return v[15:0];
    endfunction

    function automatic int maddr(input logic [10:0] opnd);
        return int'(opnd) % 1024;
    endfunction

    // Model of one executed instruction, from the architectural rules.
    task automatic model(input logic rst, input logic [1:0] sela, input logic selb,
                         input logic wa, input logic op, input logic wr,
                         input logic rd, input logic [10:0] opnd);
        logic [15:0] imm, rdv, bop, nv;
        int r;
        bit writes;
        if (rst) begin
            m_acc = 16'h0; m_z = 1'b0; m_n = 1'b0; m_o = 1'b0;
            return;
        end
        imm    = sext(opnd);
        rdv    = rd ? m_mem[maddr(opnd)] : 16'h0;
        bop    = selb ? imm : rdv;
        nv     = m_acc;
        writes = wa;
        case (sela)
            2'b00: nv = rdv;
            2'b01: nv = imm;
            2'b10: begin
                r = op ? int'($signed(m_acc)) - int'($signed(bop))
                       : int'($signed(m_acc)) + int'($signed(bop));
                if (wa && (r > 32767 || r < -32768)) m_o = 1'b1;
                nv = r[15:0];
            end
            default: writes = 1'b0;
        endcase
        if (wr) m_mem[maddr(opnd)] = m_acc;
        if (writes) begin
            m_acc = nv;
            m_z   = (nv == 16'h0);
            m_n   = nv[15];
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] sela, input logic selb,
                        input logic wa, input logic op, input logic wr,
                        input logic rd, input logic [10:0] opnd);
        reset       = rst;
        bus.SelA    = sela;
        bus.SelB    = selb;
        bus.WrAcc   = wa;
        bus.Op      = op;
        bus.WrRam   = wr;
        bus.RdRam   = rd;
        bus.Operand = opnd;
        @(posedge clk);
        model(rst, sela, selb, wa, op, wr, rd, opnd);
        #1;
    endtask

    task automatic ldi(input logic [10:0] v);  step(0, 2'b01, 0, 1, 0, 0, 0, v); endtask
    task automatic addi(input logic [10:0] v); step(0, 2'b10, 1, 1, 0, 0, 0, v); endtask
    task automatic subi(input logic [10:0] v); step(0, 2'b10, 1, 1, 1, 0, 0, v); endtask
    task automatic addv(input logic [10:0] a); step(0, 2'b10, 0, 1, 0, 0, 1, a); endtask
    task automatic subv(input logic [10:0] a); step(0, 2'b10, 0, 1, 1, 0, 1, a); endtask
    task automatic ldv(input logic [10:0] a);  step(0, 2'b00, 0, 1, 0, 0, 1, a); endtask
    task automatic sto(input logic [10:0] a);  step(0, 2'b00, 0, 0, 0, 1, 0, a); endtask
    task automatic nop();                      step(0, 2'b00, 0, 0, 0, 0, 0, 11'h0); endtask

    // Per-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_acc",  bus.Acc,  m_acc);
            chk("cyc_zero", bus.Zero, m_z);
            chk("cyc_neg",  bus.Neg,  m_n);
            chk("cyc_ovf",  bus.Ovf,  m_o);
            chk("cyc_rd",   bus.RamRdData,
                bus.RdRam ? m_mem[maddr(bus.Operand)] : 16'h0);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0;
        m_acc = 16'h0; m_z = 1'b0; m_n = 1'b0; m_o = 1'b0;

        // Reset state
        step(1, 2'b00, 0, 0, 0, 0, 0, 11'h0);
        chk_en = 1'b1;
        chk("rst_acc",  bus.Acc,  16'h0000);
        chk("rst_flags", {bus.Zero, bus.Neg, bus.Ovf}, 3'b000);

        // Immediate loads and wrap-to-zero add
        ldi(11'h005);
        chk("ldi5_acc", bus.Acc, 16'h0005);
        chk("ldi5_zn", {bus.Zero, bus.Neg}, 2'b00);
        ldi(11'h7FF);
        chk("ldi7ff_acc", bus.Acc, 16'hFFFF);
        chk("ldi7ff_neg", bus.Neg, 1'b1);
        addi(11'h001);
        chk("addi1_acc", bus.Acc, 16'h0000);
        chk("addi1_zo", {bus.Zero, bus.Ovf}, 2'b10);

        // Build 0x1234 = 0x238 + 4*0x3FF, store, reload, aliased reload
        ldi(11'h238);
        for (int i = 0; i < 4; i++) addi(11'h3FF);
        chk("build_1234", bus.Acc, 16'h1234);
        sto(11'h003);
        ldi(11'h000);
        ldv(11'h003);
        chk("ldv3_acc", bus.Acc, 16'h1234);
        ldi(11'h000);
        ldv(11'h403);
        chk("ldv403_alias", bus.Acc, 16'h1234);
        subv(11'h003);
        chk("subv3_zero", {bus.Zero, bus.Acc}, {1'b1, 16'h0000});

        // Build 0x7FFF by doubling through RAM, then overflow
        ldi(11'h200);
        for (int i = 0; i < 5; i++) begin
            sto(11'h00A);
            addv(11'h00A);
        end
        subi(11'h001);
        sto(11'h00A);
        addv(11'h00A);
        addi(11'h001);
        chk("build_7fff", bus.Acc, 16'h7FFF);
        chk("pre_ovf", bus.Ovf, 1'b0);
        addi(11'h001);
        chk("ovf_acc", bus.Acc, 16'h8000);
        chk("ovf_no", {bus.Ovf, bus.Neg}, 2'b11);
        subi(11'h000);
        chk("ovf_sticky", bus.Ovf, 1'b1);
        step(1, 2'b00, 0, 0, 0, 0, 0, 11'h0);
        chk("ovf_rst", {bus.Ovf, bus.Acc}, {1'b0, 16'h0000});

        // Same-cycle store + load at addr 5
        ldi(11'h0AA);
        sto(11'h005);
        ldi(11'h055);
        step(0, 2'b00, 0, 1, 0, 1, 1, 11'h005);
        chk("samecyc_acc", bus.Acc, 16'h00AA);
        chk("samecyc_newword", bus.RamRdData, 16'h0055);

        // Reset with WrRam/WrAcc asserted leaves RAM untouched
        ldi(11'h123);
        step(1, 2'b01, 0, 1, 0, 1, 0, 11'h005);
        chk("rstwr_acc", bus.Acc, 16'h0000);
        chk("rstwr_flags", {bus.Zero, bus.Neg, bus.Ovf}, 3'b000);
        ldv(11'h005);
        chk("rstwr_mem", bus.Acc, 16'h0055);
        step(0, 2'b00, 0, 0, 0, 0, 0, 11'h005);
        chk("rd_gate", bus.RamRdData, 16'h0000);

        // Hold cases: SelA=11 with WrAcc, and WrAcc=0
        step(0, 2'b11, 1, 1, 0, 0, 0, 11'h001);
        chk("hold_sel11", bus.Acc, 16'h0055);
        step(0, 2'b01, 0, 0, 0, 0, 0, 11'h400);
        chk("hold_nowr", bus.Acc, 16'h0055);
        ldi(11'h400);
        chk("ldi_neg", {bus.Neg, bus.Acc}, {1'b1, 16'hFC00});
        nop();
        nop();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
